imem_boot_loader: RTL and testbench

- Upstream feeder for the multi-cycle CPU. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the 1 KB instruction memory through its write port.
- Verifies a trailing XOR checksum, then asserts cpu_run to release the CPU.
- CPU stays held (cpu_run=0) while loading and after any error.

---
 rtl/imem_boot_loader_pkg.sv | 34 +++
 rtl/imem_word_packer.sv | 38 +++
 rtl/imem_boot_loader.sv | 113 +++++++++++
 tb/tb_imem_boot_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding, frame-length width and state decode helpers
//   S_IDLE..S_ERROR : loader FSM states
//   LEN_W           : width of the big-endian word-count field at the head of a frame
package imem_boot_loader_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WR,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    // States in which a byte may be taken from the stream.
    function automatic logic accepts_byte(state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    endfunction

    // States that belong to an open load session.
    function automatic logic in_session(state_t s);
        return accepts_byte(s) || s == S_WR;
    endfunction

    // States from which start opens a new session.
    function automatic logic can_start(state_t s);
        return s inside {S_IDLE, S_RUN, S_ERROR};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: big-endian byte-to-word shift register with a word-complete pulse
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart at byte 0 of a word
//   en       : accept data this cycle
//   data     : incoming byte
//   word     : assembled word including the current byte (valid when done=1)
//   done     : this byte completes a 4-byte word
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        done
);

    logic [23:0] sh;
    logic [1:0]  idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            idx <= '0;
        end else if (clr) begin
            sh  <= '0;
            idx <= '0;
        end else if (en) begin
            sh  <= {sh[15:0], data};
            idx <= idx + 2'd1;
        end
    end

    // The fourth byte is combined directly so the word is ready on the same edge.
    assign word = {sh, data};
    assign done = en && idx == 2'd3;

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream loader that fills instruction memory, verifies an XOR checksum, then releases the CPU
//   clk, rst       : clock, asynchronous active-low reset
//   start          : open a load session (from idle, run or error)
//   rx_data/valid  : incoming byte stream; rx_ready accepts a byte
//   im_we/addr/wdata : instruction-memory write port, one strobe per word
//   words_loaded   : words written in the current session
//   busy           : session in progress
//   cpu_run        : load verified, CPU released
//   error          : sticky session failure
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              busy,
    output logic              cpu_run,
    output logic              error
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] n_rx;
    logic [7:0]       csum;
    logic             xfer;
    logic             session_start;
    logic             pack_en;
    logic             pack_done;
    logic [31:0]      pack_word;
    logic             all_written;

    assign xfer          = rx_valid && rx_ready;
    assign session_start = start && can_start(state);
    assign pack_en       = xfer && state == S_DATA;
    assign n_rx          = {len[LEN_W-1:8], rx_data};
    assign all_written   = LEN_W'(words_loaded) == len;

    imem_word_packer u_packer (
        .clk  (clk),
        .rst  (rst),
        .clr  (session_start),
        .en   (pack_en),
        .data (rx_data),
        .word (pack_word),
        .done (pack_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RUN, S_ERROR: state_nxt = start ? S_LEN_HI : state;
            S_LEN_HI:               state_nxt = xfer ? S_LEN_LO : state;
            S_LEN_LO:               state_nxt = !xfer                       ? state :
                                                n_rx == '0                  ? S_CSUM :
                                                n_rx > LEN_W'(2 ** ADDR_W)  ? S_ERROR : S_DATA;
            S_DATA:                 state_nxt = pack_done ? S_WR : state;
            // words_loaded already counts the word being written here
            S_WR:                   state_nxt = all_written ? S_CSUM : S_DATA;
            S_CSUM:                 state_nxt = !xfer ? state : rx_data == csum ? S_RUN : S_ERROR;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            cpu_run      <= 1'b0;
            error        <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            words_loaded <= '0;
            len          <= '0;
            csum         <= '0;
        end else begin
            rx_ready <= accepts_byte(state_nxt);
            busy     <= in_session(state_nxt);
            cpu_run  <= state_nxt == S_RUN;
            error    <= state_nxt == S_ERROR;
            im_we    <= pack_done;
            if (pack_done) begin
                im_addr      <= words_loaded[ADDR_W-1:0];
                im_wdata     <= pack_word;
                words_loaded <= words_loaded + 1'b1;
            end
            if (pack_en) csum <= csum ^ rx_data;
            if (xfer && state == S_LEN_HI) len[LEN_W-1:8] <= rx_data;
            if (xfer && state == S_LEN_LO) len[7:0] <= rx_data;
            if (session_start) begin
                words_loaded <= '0;
                csum         <= '0;
                len          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   words_loaded;
    logic              busy;
    logic              cpu_run;
    logic              error;

    int checks = 0;
    int failures = 0;

    logic [31:0] pl [256];
    logic [39:0] wq [$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .words_loaded (words_loaded),
        .busy         (busy),
        .cpu_run      (cpu_run),
        .error        (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (im_we) wq.push_back({im_addr, im_wdata});

    function automatic logic [7:0] calc_cs(input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                c = c ^ pl[i][8*b +: 8];
        return c;
    endfunction

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            rx_data = 8'($urandom);
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 20 && !rx_ready; t++) @(negedge clk);
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte: rx_ready=%0b after 20 cycles, required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_final(input string tag, input bit ok, input int n, input int base);
        int bad = 0;
        checks++;
        if (cpu_run !== ok) begin failures++; $display("FAIL %s cpu_run: got %0b want %0b", tag, cpu_run, ok); end
        checks++;
        if (error !== !ok) begin failures++; $display("FAIL %s error: got %0b want %0b", tag, error, !ok); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s busy: got %0b want 0", tag, busy); end
        checks++;
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL %s rx_ready: got %0b want 0", tag, rx_ready); end
        checks++;
        if (words_loaded !== 9'(n)) begin failures++; $display("FAIL %s words_loaded: got %0d want %0d", tag, words_loaded, n); end
        checks++;
        if (wq.size() - base !== n) begin failures++; $display("FAIL %s write_count: got %0d want %0d", tag, wq.size() - base, n); end
        for (int i = 0; i < n && base + i < wq.size(); i++)
            if (wq[base + i] !== {8'(i), pl[i]}) begin
                if (bad == 0) $display("FAIL %s write[%0d]: got %h want %h", tag, i, wq[base + i], {8'(i), pl[i]});
                bad++;
            end
        checks++;
        if (bad != 0) failures++;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [7:0] cs, input bit gaps);
        int base = wq.size();
        start_session();
        send_byte(8'(n >> 8), gaps);
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++)
            for (int b = 3; b >= 0; b--)
                send_byte(pl[i][8*b +: 8], gaps);
        send_byte(cs, gaps);
        @(negedge clk);
        check_final(tag, cs == calc_cs(n), n, base);
    endtask

    task automatic check_all_zero(input string tag);
        logic [53:0] outs = {rx_ready, im_we, im_addr, im_wdata, words_loaded, busy, cpu_run, error};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL %s outputs: got %h want 0", tag, outs); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_idle_ignores_valid();
        int base = wq.size();
        repeat (5) begin
            rx_data = 8'($urandom);
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check_all_zero("idle_valid");
        checks++;
        if (wq.size() !== base) begin failures++; $display("FAIL idle_writes: got %0d want 0", wq.size() - base); end
    endtask

    task automatic test_known_frame();
        pl[0] = 32'h20080005;
        pl[1] = 32'h2009000A;
        run_frame("known_good", 2, calc_cs(2), 1'b0);
        checks++;
        if ({im_addr, im_wdata} !== {8'd1, 32'h2009000A}) begin
            failures++;
            $display("FAIL known_hold: got %h want %h", {im_addr, im_wdata}, {8'd1, 32'h2009000A});
        end
        run_frame("known_bad_cs", 2, 8'h00, 1'b0);
    endtask

    task automatic test_oversize();
        int base = wq.size();
        start_session();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (2) begin
            rx_valid = 1'b1;
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check_final("oversize", 1'b0, 0, base);
    endtask

    task automatic test_zero_len();
        run_frame("zero_len", 0, 8'h00, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 8; k++) begin
            int n = $urandom_range(1, 12);
            bit corrupt = $urandom_range(0, 2) == 0;
            for (int i = 0; i < n; i++) pl[i] = $urandom;
            run_frame($sformatf("rand%0d", k), n, calc_cs(n) ^ (corrupt ? 8'(1 << $urandom_range(0, 7)) : 8'h00), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) pl[i] = $urandom;
        run_frame("b2b_first", 3, calc_cs(3), 1'b0);
        for (int i = 0; i < 3; i++) pl[i] = $urandom;
        run_frame("b2b_second", 3, calc_cs(3), 1'b0);
    endtask

    task automatic test_full_memory();
        for (int i = 0; i < 256; i++) pl[i] = $urandom;
        run_frame("full_mem", 256, calc_cs(256), 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) pl[i] = $urandom;
        start_session();
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        for (int b = 0; b < 6; b++) send_byte(8'($urandom), 1'b1);
        rx_valid = 1'b1;
        #2 rst = 1'b0;
        #1 check_all_zero("reset_mid");
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) pl[i] = $urandom;
        run_frame("after_reset", 5, calc_cs(5), 1'b1);
    endtask

    initial begin
        test_reset();
        test_idle_ignores_valid();
        test_known_frame();
        test_oversize();
        test_zero_len();
        test_random_frames();
        test_back_to_back();
        test_full_memory();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
